jstk_spi_responder: RTL and testbench

//  SPI mode-0 slave that emulates a Pmod JSTK2 joystick. It answers a master's 5-byte read

---
 rtl/jstk_spi_responder.sv | 187 ++++++++++++++++++
 tb/tb_jstk_spi_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a Pmod JSTK2 joystick.
// Oversamples SCLK/SS/MOSI in the clk domain; decodes the RGB LED command.
module jstk_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_BYTES   = 5,
  parameter logic [7:0] CMD_LED     = 8'h84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [1:0] btn_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [2:0] rx_index,
  output logic [7:0] led_r,
  output logic [7:0] led_g,
  output logic [7:0] led_b,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sy, ss_sy, mosi_sy;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [9:0]      x_q, y_q;
  logic [1:0]      btn_q;
  logic [6:0]      tx, rx_sr;
  logic            miso_q;
  logic [2:0]      rx_bits, tx_bits, byte_cnt, tx_idx, tx_nx;
  logic [3:0][7:0] cmd;
  logic [7:0]      resp_nx, rx_full;

  assign sclk_s = sclk_sy[SYNC_STAGES-1];
  assign ss_s   = ss_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign MISO    = miso_q;
  assign rx_full = {rx_sr, mosi_s};
  assign tx_nx   = (tx_idx == 3'd7) ? 3'd7 : tx_idx + 3'd1;

  function automatic logic [7:0] resp(
    input logic [2:0] i,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [1:0] b
  );
    logic [7:0] r;
    r = 8'h00;
    case (i)
      3'd0:    r = x[7:0];
      3'd1:    r = {6'b0, x[9:8]};
      3'd2:    r = y[7:0];
      3'd3:    r = {6'b0, y[9:8]};
      3'd4:    r = {6'b0, b};
      default: r = 8'h00;
    endcase
    if (int'(i) >= NUM_BYTES) r = 8'h00;
    return r;
  endfunction

  assign resp_nx = resp(tx_nx, x_q, y_q, btn_q);

  // SS sync resets low so a frame needs a genuine falling edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sy <= '0;
      ss_sy   <= '0;
      mosi_sy <= '0;
      sclk_d  <= 1'b0;
      ss_d    <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], SCLK};
      ss_sy   <= {ss_sy[SYNC_STAGES-2:0], SS};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], MOSI};
      sclk_d  <= sclk_s;
      ss_d    <= ss_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE:    if (ss_fall) state_nx = LOAD;
      LOAD:    state_nx = ss_rise ? COMMIT : SHIFT;
      SHIFT:   if (ss_rise) state_nx = COMMIT;
      COMMIT: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      y_q      <= '0;
      btn_q    <= '0;
      tx       <= '0;
      rx_sr    <= '0;
      miso_q   <= 1'b0;
      rx_bits  <= '0;
      tx_bits  <= '0;
      byte_cnt <= '0;
      tx_idx   <= '0;
      cmd      <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_index <= '0;
      led_r    <= '0;
      led_g    <= '0;
      led_b    <= '0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: miso_q <= 1'b0;
        LOAD: begin
          x_q      <= x_in;
          y_q      <= y_in;
          btn_q    <= btn_in;
          tx       <= x_in[6:0];
          miso_q   <= ss_rise ? 1'b0 : x_in[7];
          rx_bits  <= '0;
          tx_bits  <= '0;
          byte_cnt <= '0;
          tx_idx   <= '0;
        end
        SHIFT: begin
          if (ss_rise) begin
            miso_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr   <= rx_full[6:0];
            rx_bits <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) begin
              rx_byte  <= rx_full;
              rx_valid <= 1'b1;
              rx_index <= byte_cnt;
              if (!byte_cnt[2]) cmd[byte_cnt[1:0]] <= rx_full;
              if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (sclk_fall) begin
            tx_bits <= tx_bits + 3'd1;
            if (tx_bits == 3'd7) begin
              tx     <= resp_nx[6:0];
              miso_q <= resp_nx[7];
              tx_idx <= tx_nx;
            end else begin
              tx     <= {tx[5:0], 1'b0};
              miso_q <= tx[6];
            end
          end
        end
        COMMIT: begin
          miso_q <= 1'b0;
          if (byte_cnt >= 3'd4 && cmd[0] == CMD_LED) begin
            led_r <= cmd[1];
            led_g <= cmd[2];
            led_b <= cmd[3];
          end
        end
        default: miso_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: directed SPI frames,
// queue-based scoreboard for MISO bytes, rx bytes and LED state.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SCLK, SS, MOSI, MISO;
  logic [9:0] x_in, y_in;
  logic [1:0] btn_in;
  logic [7:0] rx_byte, led_r, led_g, led_b;
  logic       rx_valid, frame_done;
  logic [2:0] rx_index;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mo [0:15];
  logic [7:0]  ev [0:15];
  logic [7:0]  exp_tx [$];
  logic [10:0] exp_rx [$];
  logic [23:0] exp_led [$];

  always #5 clk = ~clk;

  jstk_spi_responder dut (
    .clk        (clk),
    .rst        (rst_n),
    .SCLK       (SCLK),
    .SS         (SS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .x_in       (x_in),
    .y_in       (y_in),
    .btn_in     (btn_in),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_index   (rx_index),
    .led_r      (led_r),
    .led_g      (led_g),
    .led_b      (led_b),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic set_mo(input logic [7:0] a, b, c, d, e);
    for (int k = 0; k < 16; k++) mo[k] = 8'h00;
    mo[0] = a; mo[1] = b; mo[2] = c; mo[3] = d; mo[4] = e;
  endtask

  task automatic set_ev(input logic [7:0] a, b, c, d, e);
    for (int k = 0; k < 16; k++) ev[k] = 8'h00;
    ev[0] = a; ev[1] = b; ev[2] = c; ev[3] = d; ev[4] = e;
  endtask

  task automatic expect_frame(input int ntx, input int nrx,
                              input logic [23:0] led, input bit ends);
    for (int k = 0; k < ntx; k++) exp_tx.push_back(ev[k]);
    for (int k = 0; k < nrx; k++)
      exp_rx.push_back({mo[k], (k > 7) ? 3'd7 : 3'(k)});
    if (ends) exp_led.push_back(led);
  endtask

  task automatic spi_frame(input int nbits, input int half, input bit raise);
    @(negedge clk);
    SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[i / 8][7 - (i % 8)];
      repeat (half) @(negedge clk);
      SCLK = 1'b1;
      repeat (half) @(negedge clk);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    repeat (half) @(negedge clk);
    if (raise) begin
      SS = 1'b1;
      repeat (2 * half + 10) @(negedge clk);
    end
  endtask

  // MISO monitor: master-side view, sampled at each SCLK rise
  logic [7:0] mshift;
  int         mbits = 0;
  always @(posedge SCLK or posedge SS) begin
    if (SS) begin
      mbits = 0;
    end else begin
      mshift = {mshift[6:0], MISO};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (exp_tx.size() == 0) check("miso_unexpected", 32'(mshift), 32'hFFFF);
        else check("miso_byte", 32'(mshift), 32'(exp_tx.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        check("rx_unexpected", {rx_index, rx_byte}, 32'hFFFF);
      end else begin
        logic [10:0] e;
        e = exp_rx.pop_front();
        check("rx_byte", 32'(rx_byte), 32'(e[10:3]));
        check("rx_index", 32'(rx_index), 32'(e[2:0]));
      end
    end
  end

  // LEDs are compared one clk after each frame_done pulse
  logic fd_d = 1'b0;
  always @(negedge clk) begin
    if (fd_d) begin
      if (exp_led.size() == 0) check("frame_done_unexpected", 32'(fd_d), 32'h0);
      else check("led_after_frame", {8'h0, led_r, led_g, led_b},
                 32'(exp_led.pop_front()));
    end
    fd_d = frame_done;
  end

  initial begin
    rst_n = 1'b0; SCLK = 1'b0; SS = 1'b1; MOSI = 1'b0;
    x_in = '0; y_in = '0; btn_in = '0;

    // reset held with SS toggling
    for (int k = 0; k < 4; k++) begin
      repeat (6) @(negedge clk);
      SS = ~SS;
    end
    repeat (6) @(negedge clk);
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_leds", {8'h0, led_r, led_g, led_b}, 32'h0);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    check("rst_rx_index", 32'(rx_index), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    SS = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_miso", 32'(MISO), 32'h0);

    // plain read at 1 MHz SCLK
    x_in = 10'h2A5; y_in = 10'h0F3; btn_in = 2'b10;
    set_mo(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_ev(8'hA5, 8'h02, 8'hF3, 8'h00, 8'h02);
    expect_frame(5, 5, 24'h000000, 1'b1);
    spi_frame(40, 50, 1'b1);

    // LED command, then a non-LED command
    set_mo(8'h84, 8'h11, 8'h22, 8'h33, 8'h00);
    expect_frame(5, 5, 24'h112233, 1'b1);
    spi_frame(40, 10, 1'b1);
    set_mo(8'h85, 8'hAA, 8'hBB, 8'hCC, 8'h00);
    expect_frame(5, 5, 24'h112233, 1'b1);
    spi_frame(40, 10, 1'b1);

    // abort after 13 bits, then a full frame restarts at b0
    set_mo(8'h84, 8'h55, 8'h00, 8'h00, 8'h00);
    expect_frame(1, 1, 24'h112233, 1'b1);
    spi_frame(13, 10, 1'b1);
    set_mo(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_frame(5, 5, 24'h112233, 1'b1);
    spi_frame(40, 10, 1'b1);

    // snapshot: x_in changes early in the frame
    expect_frame(5, 5, 24'h112233, 1'b1);
    fork
      spi_frame(40, 10, 1'b1);
      begin
        repeat (40) @(negedge clk);
        x_in = 10'h001;
      end
    join

    // overrun: 9 bytes, tail reads 00 and rx_index saturates
    set_mo(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    mo[5] = 8'h06; mo[6] = 8'h07; mo[7] = 8'h08; mo[8] = 8'h09;
    set_ev(8'h01, 8'h00, 8'hF3, 8'h00, 8'h02);
    expect_frame(9, 9, 24'h112233, 1'b1);
    spi_frame(72, 10, 1'b1);

    // minimum SCLK half-period
    x_in = 10'h3FF; y_in = 10'h2FF; btn_in = 2'b01;
    set_mo(8'h84, 8'hA1, 8'hB2, 8'hC3, 8'h5A);
    set_ev(8'hFF, 8'h03, 8'hFF, 8'h02, 8'h01);
    expect_frame(5, 5, 24'hA1B2C3, 1'b1);
    spi_frame(40, 5, 1'b1);

    // reset after 20 bits: no frame_done, LEDs clear
    set_mo(8'h84, 8'hEE, 8'hEE, 8'hEE, 8'h00);
    expect_frame(2, 2, 24'h000000, 1'b0);
    spi_frame(20, 5, 1'b0);
    check("pre_reset_miso", 32'(MISO), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_miso", 32'(MISO), 32'h0);
    @(negedge clk);
    SS = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_leds", {8'h0, led_r, led_g, led_b}, 32'h0);
    check("post_rst_miso", 32'(MISO), 32'h0);

    set_mo(8'h84, 8'h01, 8'h02, 8'h03, 8'h00);
    expect_frame(5, 5, 24'h010203, 1'b1);
    spi_frame(40, 5, 1'b1);

    repeat (20) @(negedge clk);
    check("exp_tx_left", 32'(exp_tx.size()), 32'h0);
    check("exp_rx_left", 32'(exp_rx.size()), 32'h0);
    check("exp_led_left", 32'(exp_led.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
